// File: rtl/uart_pkg.sv
// Shared state encodings and status-bit positions for the UART MMIO engine.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned TX_BUSY   = 0;
  localparam int unsigned RX_READY  = 1;
  localparam int unsigned OVERRUN   = 2;
  localparam int unsigned FRAME_ERR = 3;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM and sticky/ack-cleared status flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx_ack,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF_BIT - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_ready_q, rx_ready_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    sync1_d     = uart_rxd;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (rx_ack) begin
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A line stuck low after a bad stop bit must return high before a new start counts.
        armed_d = armed_q | sync2_q;
        if (rx_en && armed_q && !sync2_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          armed_d = sync2_q;
          if (sync2_q) begin
            rx_data_d  = shift_q;
            rx_ready_d = 1'b1;
            if (rx_ready_q && !rx_ack) overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      armed_q     <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_mmio_engine.sv
// UART engine behind the MMIO register block: 8N1 transmitter plus uart_rx receiver.
module uart_mmio_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx_ack,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       tx_done,
  output logic [3:0] status
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_busy_q, tx_busy_d;
  logic          rx_ready, overrun, frame_err;

  // Line value is computed from the next state so uart_txd changes together with the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    tx_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (tx_start && tx_en) begin
          shift_d = tx_data;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          tx_done_d = 1'b1;
          txd_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      tx_done_q <= tx_done_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .rx_ack    (rx_ack),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always_comb begin
    status            = 4'b0000;
    status[TX_BUSY]   = tx_busy_q;
    status[RX_READY]  = rx_ready;
    status[OVERRUN]   = overrun;
    status[FRAME_ERR] = frame_err;
  end

  assign uart_txd = txd_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_mmio_engine.sv
// Self-checking bench for uart_mmio_engine: vector tables, corner sequences and random traffic.
module tb_uart_mmio_engine;

  localparam int CPB  = 8;
  localparam int HALF = 4;

  localparam int K_FRAME  = 0;
  localparam int K_ACK    = 1;
  localparam int K_GLITCH = 2;

  logic       clk = 1'b0;
  logic       reset, tx_en, rx_en, tx_start, rx_ack, uart_rxd;
  logic [7:0] tx_data;
  logic       uart_txd, tx_done;
  logic [7:0] rx_data;
  logic [3:0] status;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic       en;
    int         inj_at;
    logic [7:0] inj_d;
    int         drop_at;
  } tx_vec_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       stopb;
    logic       en;
    int         ack_at;
    logic [7:0] exp_data;
    logic [3:0] exp_status;
  } rx_vec_t;

  tx_vec_t tx_tab[5];
  rx_vec_t rx_tab[10];

  uart_mmio_engine #(
    .CLKS_PER_BIT (CPB),
    .HALF_BIT     (HALF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .rx_ack   (rx_ack),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .status   (status)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Bit k of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic tx_run(input logic [7:0] d, input logic en, input int inj_at,
                        input logic [7:0] inj_d, input int drop_at, input string tag);
    int line_err = 0;
    int busy_err = 0;
    int done_cnt = 0;
    int done_at  = -1;
    logic exp_line, exp_busy;
    tx_en    = en;
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
    for (int i = 0; i < 12 * CPB; i++) begin
      exp_busy = en && (i < 10 * CPB);
      exp_line = exp_busy ? frame_bit(d, i / CPB) : 1'b1;
      if (uart_txd !== exp_line) line_err++;
      if (status[0] !== exp_busy) busy_err++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (i == inj_at) begin
        tx_start = 1'b1;
        tx_data  = inj_d;
      end else begin
        tx_start = 1'b0;
      end
      if (i == drop_at) tx_en = 1'b0;
      @(negedge clk);
    end
    tx_start = 1'b0;
    check({tag, "_line_errs"}, line_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_done_count"}, done_cnt, en ? 1 : 0);
    if (en) check({tag, "_done_cycle"}, done_at, 10 * CPB);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stopb, input logic en, input int ack_at);
    rx_en = en;
    for (int i = 0; i < 10 * CPB; i++) begin
      uart_rxd = (i / CPB == 9) ? stopb : frame_bit(d, i / CPB);
      rx_ack   = (i == ack_at);
      @(negedge clk);
    end
    rx_ack   = 1'b0;
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic glitch_low();
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] m_data, d;
    logic       m_ready, m_ov;

    tx_tab[0] = '{8'hA5, 1'b1, -1, 8'h00, -1};
    tx_tab[1] = '{8'hA5, 1'b1, 20, 8'h3C, -1};
    tx_tab[2] = '{8'h3C, 1'b0, -1, 8'h00, -1};
    tx_tab[3] = '{8'hFF, 1'b1, 79, 8'h00, -1};
    tx_tab[4] = '{8'h5A, 1'b1, -1, 8'h00, 30};

    rx_tab[0] = '{K_FRAME,  8'h6E, 1'b1, 1'b1, -1, 8'h6E, 4'b0010};
    rx_tab[1] = '{K_ACK,    8'h00, 1'b1, 1'b1, -1, 8'h6E, 4'b0000};
    rx_tab[2] = '{K_FRAME,  8'h11, 1'b1, 1'b1, -1, 8'h11, 4'b0010};
    rx_tab[3] = '{K_FRAME,  8'h22, 1'b1, 1'b1, -1, 8'h22, 4'b0110};
    rx_tab[4] = '{K_FRAME,  8'h33, 1'b1, 1'b1, 78, 8'h33, 4'b0010};
    rx_tab[5] = '{K_ACK,    8'h00, 1'b1, 1'b1, -1, 8'h33, 4'b0000};
    rx_tab[6] = '{K_GLITCH, 8'h00, 1'b1, 1'b1, -1, 8'h33, 4'b0000};
    rx_tab[7] = '{K_FRAME,  8'h55, 1'b0, 1'b1, -1, 8'h33, 4'b1000};
    rx_tab[8] = '{K_FRAME,  8'hC3, 1'b1, 1'b0, -1, 8'h33, 4'b1000};
    rx_tab[9] = '{K_FRAME,  8'hA7, 1'b1, 1'b1, -1, 8'hA7, 4'b1010};

    reset    = 1'b1;
    tx_en    = 1'b0;
    rx_en    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    rx_ack   = 1'b0;
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_txd", int'(uart_txd), 1);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_status", int'(status), 0);
    check("rst_tx_done", int'(tx_done), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++)
      tx_run(tx_tab[i].data, tx_tab[i].en, tx_tab[i].inj_at, tx_tab[i].inj_d,
             tx_tab[i].drop_at, $sformatf("tx_vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      case (rx_tab[i].kind)
        K_ACK:    ack_pulse();
        K_GLITCH: glitch_low();
        default:  rx_send(rx_tab[i].data, rx_tab[i].stopb, rx_tab[i].en, rx_tab[i].ack_at);
      endcase
      check($sformatf("rx_vec%0d_data", i), int'(rx_data), int'(rx_tab[i].exp_data));
      check($sformatf("rx_vec%0d_status", i), int'(status), int'(rx_tab[i].exp_status));
    end

    // Asynchronous reset in the middle of a TX frame and an RX frame.
    tx_en    = 1'b1;
    rx_en    = 1'b1;
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    uart_rxd = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (35) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_txd", int'(uart_txd), 1);
    check("midrst_status", int'(status), 0);
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_tx_done", int'(tx_done), 0);
    @(negedge clk);
    reset    = 1'b0;
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_status", int'(status), 0);
    check("postrst_rx_data", int'(rx_data), 0);
    tx_run(8'hA5, 1'b1, -1, 8'h00, -1, "tx_postrst");

    for (int i = 0; i < 3; i++)
      tx_run(8'($urandom), 1'b1, -1, 8'h00, -1, $sformatf("tx_rand%0d", i));

    m_data  = 8'h00;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        m_ready = 1'b0;
        m_ov    = 1'b0;
      end
      rx_send(d, 1'b1, 1'b1, -1);
      m_ov    = m_ov | m_ready;
      m_ready = 1'b1;
      m_data  = d;
      check($sformatf("rx_rand%0d_data", i), int'(rx_data), int'(m_data));
      check($sformatf("rx_rand%0d_status", i), int'(status), int'({1'b0, m_ov, m_ready, 1'b0}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
